codec_cfg_ctrl: RTL and testbench
=================================

Name: codec_cfg_ctrl

Overview:
- Sequences all audio-codec (WM8731) register writes over the shared I2C write engine.
- After reset it streams a fixed 10-entry init table, retrying NACKed writes, and then raises init_done.
- It then arbitrates runtime requests (DAC soft-mute, headphone volume) for the same engine, issuing one 16-bit register word per transaction.
- It sits between the top-level control logic (keys/FSM) and the bit-level I2C engine that drives sclk/sdat.

Parameters:
- NUM_INIT, 10, number of init-table entries.
- GAP_CYCLES, 1000, idle clk_n cycles inserted after every completed transaction (settle time); must be >= 1.
- MAX_RETRY, 3, re-issues allowed after a NACK before a write is declared failed.
- GAP_W, 10, width of the gap counter; must hold GAP_CYCLES.

Ports:
- clk_n  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- req_mute  in  1  mute request level; held until ack_mute.
- mute_en  in  1  mute value; sampled when the mute write is issued.
- ack_mute  out  1  one-cycle pulse: mute write finished.
- req_vol  in  1  volume request level; held until ack_vol.
- vol_data  in  7  headphone volume code; sampled at issue.
- ack_vol  out  1  one-cycle pulse: volume write finished.
- wr_valid  out  1  word offered to the I2C engine.
- wr_ready  in  1  engine accepts; transfer occurs when wr_valid & wr_ready.
- wr_word  out  16  {reg_addr[6:0], reg_data[8:0]}.
- wr_done  in  1  one-cycle pulse: engine transaction ended.
- wr_nack  in  1  qualified by wr_done: 1 = slave NACK.
- init_done  out  1  init table complete; sticky until reset.
- busy  out  1  high in any state except RUN_IDLE and ERROR.
- err  out  1  sticky: some write exhausted its retries.
- err_idx  out  4  source of the last failure: 0..9 init entry, 14 volume, 15 mute.

Behaviour:
- Reset (rst=0 at a clk_n edge): state = INIT_ISSUE with idx=0 and retry=0.
  - Outputs reset to: wr_valid=0, wr_word=0, init_done=0, busy=0, err=0, err_idx=0, acks=0.
  - busy goes high the first cycle after reset releases.
  - A reset mid-transaction aborts immediately; the engine shares the same rst.
- States: INIT_ISSUE, INIT_WAIT, INIT_GAP, RUN_IDLE, RUN_ISSUE, RUN_WAIT, RUN_GAP, ERROR.
- ISSUE states:
  - wr_valid=1 with wr_word stable; wr_word is a registered output.
  - On valid&ready, go to the WAIT state in the next cycle, drop wr_valid, and keep wr_word.
- WAIT states wait for wr_done:
  - nack=0: success; go to GAP.
  - nack=1 and retry<MAX_RETRY: retry++, go to GAP, then re-issue the same word.
  - nack=1 and retry==MAX_RETRY: failure.
- GAP: count GAP_CYCLES cycles, then go to the next state.
- Init advance: after a successful GAP, idx++ and retry=0.
  - After entry NUM_INIT-1, go to RUN_IDLE and set init_done=1 on entry.
- Init failure: err=1, err_idx=idx, go to ERROR.
  - ERROR holds until reset; init_done stays 0 and requests are never acked.
- Requests are ignored (no ack) until RUN_IDLE; they remain pending and are served afterwards.
- RUN_IDLE arbitration: fixed priority, mute over volume.
  - Simultaneous requests: mute first, volume after mute's gap.
  - The chosen word is latched on entry to RUN_ISSUE.
- Runtime completion: the ack pulse occurs in the cycle after wr_done (success or final failure).
  - Final failure also sets err=1 and err_idx=15 (mute) or 14 (volume), then RUN_GAP.
  - A request that is still high after its ack is treated as a new request.
- Runtime words:
  - Volume: 0x0500 | vol_data (R2, LRHPBOTH=1, LZCEN=0).
  - Mute: 0x0A00 | (mute_en<<3) (R5, DACMU).
- A wr_done outside the WAIT states is ignored.
- Init table, in order:
  - idx 0..4: 1E00 (reset), 0C00 (power all on), 0017 (L line in), 0217 (R line in), 0579 (HP both, 0 dB).
  - idx 5..9: 0814 (mic to ADC, DAC select), 0A00 (unmute), 0E42 (master, I2S, 16-bit), 1000 (48 kHz normal), 1201 (active).

Decomposition:
- Shared package/header: the state encoding, the codec register addresses (R0..R15), the word builders for volume and mute, and the ERR_IDX_VOL=14 / ERR_IDX_MUTE=15 constants.
- Sub-module codec_init_rom: combinational idx[3:0] -> 16-bit word lookup; indices >= NUM_INIT return 0.

Test Plan:
(Bench settings: GAP_CYCLES=4. The engine model asserts wr_ready 2 cycles after wr_valid and wr_done 20 cycles after acceptance.)
- Reset released, engine always ACKs:
  - Words 1E00, 0C00, 0017, 0217, 0579, 0814, 0A00, 0E42, 1000, 1201 are seen in order, each exactly once.
  - init_done rises the cycle after the last gap; err=0.
- NACK on idx 3 twice, then ACK: 0217 is issued 3 times, err=0, and init completes normally.
- NACK on idx 7 always: 0E42 is issued 4 times, err=1, err_idx=7, busy=0, init_done=0; a later req_vol receives no ack.
- After init, req_mute=1 (mute_en=1) and req_vol=1 (vol_data=7'h70) in the same cycle:
  - 0A08 is issued, then ack_mute pulses.
  - After 4 gap cycles 0570 is issued, then ack_vol pulses.
- req_vol=1 asserted during init idx 2: no grant before init_done; 0570 is issued immediately after init_done.
- rst=0 while in INIT_WAIT at idx 5:
  - Next cycle wr_valid=0, init_done=0, busy=0.
  - After release the sequence restarts at 1E00.

Source files
------------

// File: rtl/codec_cfg_ctrl_pkg.sv
// Shared types, WM8731 register map and word builders for the codec config controller.
package codec_cfg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT_ISSUE = 3'd0,
    ST_INIT_WAIT  = 3'd1,
    ST_INIT_GAP   = 3'd2,
    ST_RUN_IDLE   = 3'd3,
    ST_RUN_ISSUE  = 3'd4,
    ST_RUN_WAIT   = 3'd5,
    ST_RUN_GAP    = 3'd6,
    ST_ERROR      = 3'd7
  } state_t;

  // Which runtime requester owns the transaction in flight.
  typedef enum logic {
    SRC_VOL  = 1'b0,
    SRC_MUTE = 1'b1
  } src_t;

  // WM8731 register addresses (7-bit).
  localparam logic [6:0] R0_LLINE_IN  = 7'h00;
  localparam logic [6:0] R1_RLINE_IN  = 7'h01;
  localparam logic [6:0] R2_LHP_OUT   = 7'h02;
  localparam logic [6:0] R3_RHP_OUT   = 7'h03;
  localparam logic [6:0] R4_ANA_PATH  = 7'h04;
  localparam logic [6:0] R5_DIG_PATH  = 7'h05;
  localparam logic [6:0] R6_PWR_DOWN  = 7'h06;
  localparam logic [6:0] R7_DIG_IF    = 7'h07;
  localparam logic [6:0] R8_SAMPLING  = 7'h08;
  localparam logic [6:0] R9_ACTIVE    = 7'h09;
  localparam logic [6:0] R15_RESET    = 7'h0F;

  localparam logic [3:0] ERR_IDX_VOL  = 4'd14;
  localparam logic [3:0] ERR_IDX_MUTE = 4'd15;

  function automatic logic [15:0] make_word(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

  // R2 with LRHPBOTH=1, LZCEN=0 and the 7-bit volume code.
  function automatic logic [15:0] vol_word(input logic [6:0] vol);
    return make_word(R2_LHP_OUT, {2'b10, vol});
  endfunction

  // R5 with DACMU at bit 3, everything else cleared.
  function automatic logic [15:0] mute_word(input logic mute);
    return make_word(R5_DIG_PATH, {5'b0_0000, mute, 3'b000});
  endfunction

endpackage

// File: rtl/codec_cfg_ctrl_rom.sv
// Power-up register sequence for the WM8731; out-of-range indices read as zero.
module codec_init_rom
  import codec_cfg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_INIT = 10
) (
  input  logic [3:0]  idx,
  output logic [15:0] word
);

  // Fixed table lookup.
  always_comb begin
    word = '0;
    case (idx)
      4'd0:    word = make_word(R15_RESET,   9'h000);
      4'd1:    word = make_word(R6_PWR_DOWN, 9'h000);
      4'd2:    word = make_word(R0_LLINE_IN, 9'h017);
      4'd3:    word = make_word(R1_RLINE_IN, 9'h017);
      4'd4:    word = make_word(R2_LHP_OUT,  9'h179);
      4'd5:    word = make_word(R4_ANA_PATH, 9'h014);
      4'd6:    word = make_word(R5_DIG_PATH, 9'h000);
      4'd7:    word = make_word(R7_DIG_IF,   9'h042);
      4'd8:    word = make_word(R8_SAMPLING, 9'h000);
      4'd9:    word = make_word(R9_ACTIVE,   9'h001);
      default: word = '0;
    endcase
    if (32'(idx) >= NUM_INIT) word = '0;
  end

endmodule

// File: rtl/codec_cfg_ctrl.sv
// Sequences WM8731 init writes, then arbitrates mute/volume requests onto the I2C write engine.
module codec_cfg_ctrl
  import codec_cfg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_INIT   = 10,
  parameter int unsigned GAP_CYCLES = 1000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_W      = 10
) (
  input  logic        clk_n,
  input  logic        rst,
  input  logic        req_mute,
  input  logic        mute_en,
  output logic        ack_mute,
  input  logic        req_vol,
  input  logic [6:0]  vol_data,
  output logic        ack_vol,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [15:0] wr_word,
  input  logic        wr_done,
  input  logic        wr_nack,
  output logic        init_done,
  output logic        busy,
  output logic        err,
  output logic [3:0]  err_idx
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]         IDX_LAST   = 4'(NUM_INIT - 1);

  state_t             state, state_n;
  logic [3:0]         idx, idx_n;
  logic [RETRY_W-1:0] retry, retry_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic               done, done_n;
  src_t               src, src_n;
  logic [15:0]        word_hold, word_n, rom_word;
  logic               valid_n, busy_n, init_done_n, err_n;
  logic [3:0]         err_idx_n;
  logic               ack_mute_n, ack_vol_n;

  // ROM is addressed with the next index so the word is ready on entry to INIT_ISSUE.
  codec_init_rom #(.NUM_INIT(NUM_INIT)) u_rom (
    .idx  (idx_n),
    .word (rom_word)
  );

  // Next-state and bookkeeping decisions.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    retry_n     = retry;
    gap_n       = gap_cnt;
    done_n      = done;
    src_n       = src;
    word_hold   = wr_word;
    init_done_n = init_done;
    err_n       = err;
    err_idx_n   = err_idx;
    ack_mute_n  = 1'b0;
    ack_vol_n   = 1'b0;
    case (state)
      ST_INIT_ISSUE: if (wr_valid && wr_ready) state_n = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (wr_done) begin
          if (!wr_nack) begin
            done_n  = 1'b1;
            gap_n   = '0;
            state_n = ST_INIT_GAP;
          end else if (retry < RETRY_LAST) begin
            retry_n = retry + 1'b1;
            done_n  = 1'b0;
            gap_n   = '0;
            state_n = ST_INIT_GAP;
          end else begin
            err_n     = 1'b1;
            err_idx_n = idx;
            state_n   = ST_ERROR;
          end
        end
      end
      ST_INIT_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (!done) begin
            state_n = ST_INIT_ISSUE;
          end else if (idx == IDX_LAST) begin
            init_done_n = 1'b1;
            state_n     = ST_RUN_IDLE;
          end else begin
            idx_n   = idx + 4'd1;
            retry_n = '0;
            state_n = ST_INIT_ISSUE;
          end
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      ST_RUN_IDLE: begin
        if (req_mute) begin
          src_n     = SRC_MUTE;
          word_hold = mute_word(mute_en);
          retry_n   = '0;
          state_n   = ST_RUN_ISSUE;
        end else if (req_vol) begin
          src_n     = SRC_VOL;
          word_hold = vol_word(vol_data);
          retry_n   = '0;
          state_n   = ST_RUN_ISSUE;
        end
      end
      ST_RUN_ISSUE: if (wr_valid && wr_ready) state_n = ST_RUN_WAIT;
      ST_RUN_WAIT: begin
        if (wr_done) begin
          gap_n   = '0;
          state_n = ST_RUN_GAP;
          if (wr_nack && (retry < RETRY_LAST)) begin
            retry_n = retry + 1'b1;
            done_n  = 1'b0;
          end else begin
            done_n     = 1'b1;
            ack_mute_n = (src == SRC_MUTE);
            ack_vol_n  = (src == SRC_VOL);
            if (wr_nack) begin
              err_n     = 1'b1;
              err_idx_n = (src == SRC_MUTE) ? ERR_IDX_MUTE : ERR_IDX_VOL;
            end
          end
        end
      end
      ST_RUN_GAP: begin
        if (gap_cnt == GAP_LAST) state_n = done ? ST_RUN_IDLE : ST_RUN_ISSUE;
        else gap_n = gap_cnt + 1'b1;
      end
      ST_ERROR: state_n = ST_ERROR;
      default:  state_n = ST_ERROR;
    endcase
  end

  // Registered-output values derived from the next state.
  always_comb begin
    word_n  = word_hold;
    if (state_n == ST_INIT_ISSUE) word_n = rom_word;
    valid_n = (state_n == ST_INIT_ISSUE) || (state_n == ST_RUN_ISSUE);
    busy_n  = (state_n != ST_RUN_IDLE) && (state_n != ST_ERROR);
  end

  // State and output registers.
  always_ff @(posedge clk_n) begin
    if (!rst) begin
      state     <= ST_INIT_ISSUE;
      idx       <= '0;
      retry     <= '0;
      gap_cnt   <= '0;
      done      <= 1'b0;
      src       <= SRC_VOL;
      wr_valid  <= 1'b0;
      wr_word   <= '0;
      init_done <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_idx   <= '0;
      ack_mute  <= 1'b0;
      ack_vol   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      retry     <= retry_n;
      gap_cnt   <= gap_n;
      done      <= done_n;
      src       <= src_n;
      wr_valid  <= valid_n;
      wr_word   <= word_n;
      init_done <= init_done_n;
      busy      <= busy_n;
      err       <= err_n;
      err_idx   <= err_idx_n;
      ack_mute  <= ack_mute_n;
      ack_vol   <= ack_vol_n;
    end
  end

endmodule

// File: tb/tb_codec_cfg_ctrl.sv
// Scoreboard bench for codec_cfg_ctrl with a behavioural I2C write-engine model.
module tb_codec_cfg_ctrl;

  localparam int GAP = 4;
  localparam int EV_WORD = 0;
  localparam int EV_MUTE = 1;
  localparam int EV_VOL  = 2;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  logic        clk_n = 1'b0;
  logic        rst = 1'b0;
  logic        req_mute = 1'b0, mute_en = 1'b0, req_vol = 1'b0;
  logic [6:0]  vol_data = '0;
  logic        ack_mute, ack_vol, wr_valid, init_done, busy, err;
  logic        wr_ready = 1'b0, wr_done = 1'b0, wr_nack = 1'b0;
  logic [15:0] wr_word;
  logic [3:0]  err_idx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int ack_count = 0;
  ev_t exp_q[$];

  logic [15:0] init_tbl [10] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0579,
                                 16'h0814, 16'h0A00, 16'h0E42, 16'h1000, 16'h1201};

  // Engine configuration (written by stimulus) and engine-private state.
  logic [15:0] nack_word = 16'h0;
  int          nack_limit = 0;
  int          nack_used = 0;
  int          eng_phase = 0;
  int          eng_cnt = 0;
  logic [15:0] eng_word = 16'h0;

  codec_cfg_ctrl #(
    .NUM_INIT   (10),
    .GAP_CYCLES (GAP),
    .MAX_RETRY  (3),
    .GAP_W      (10)
  ) dut (
    .clk_n     (clk_n),
    .rst       (rst),
    .req_mute  (req_mute),
    .mute_en   (mute_en),
    .ack_mute  (ack_mute),
    .req_vol   (req_vol),
    .vol_data  (vol_data),
    .ack_vol   (ack_vol),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_word   (wr_word),
    .wr_done   (wr_done),
    .wr_nack   (wr_nack),
    .init_done (init_done),
    .busy      (busy),
    .err       (err),
    .err_idx   (err_idx)
  );

  always #5 clk_n = ~clk_n;

  always @(posedge clk_n) cyc++;

  // Engine model: ready 2 cycles after valid, done 20 cycles after acceptance.
  always @(posedge clk_n) begin
    #1;
    wr_done = 1'b0;
    wr_nack = 1'b0;
    if (!rst) begin
      wr_ready  = 1'b0;
      eng_phase = 0;
      eng_cnt   = 0;
      nack_used = 0;
    end else begin
      case (eng_phase)
        0: if (wr_valid) begin
          eng_cnt++;
          if (eng_cnt == 2) begin
            wr_ready  = 1'b1;
            eng_phase = 1;
          end
        end
        1: begin
          wr_ready  = 1'b0;
          eng_word  = wr_word;
          eng_cnt   = 0;
          eng_phase = 2;
        end
        default: begin
          eng_cnt++;
          if (eng_cnt == 20) begin
            wr_done = 1'b1;
            if (eng_word == nack_word && nack_used < nack_limit) begin
              wr_nack = 1'b1;
              nack_used++;
            end
            eng_phase = 0;
            eng_cnt   = 0;
          end
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic got(input int kind, input logic [15:0] val);
    ev_t e;
    logic [15:0] k;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind=%0d val=%h want none (t=%0t)", kind, val, $time);
    end else begin
      e = exp_q.pop_front();
      k = 16'(kind);
      check("event", {k, val}, {16'(e.kind), e.val});
    end
  endtask

  // Monitor: every accepted word and every ack pulse is checked against the queue.
  always @(negedge clk_n) begin
    if (rst) begin
      if (wr_done) last_done_cyc = cyc;
      if (ack_mute) begin ack_count++; got(EV_MUTE, 16'h0); end
      if (ack_vol)  begin ack_count++; got(EV_VOL, 16'h0);  end
      if (wr_valid && wr_ready) got(EV_WORD, wr_word);
    end
  end

  task automatic push_ev(input int kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Push init words 0..upto-1; entry rep_idx is pushed rep_n times.
  task automatic push_init(input int rep_idx, input int rep_n, input int upto);
    for (int i = 0; i < upto; i++) begin
      if (i == rep_idx) for (int r = 0; r < rep_n; r++) push_ev(EV_WORD, init_tbl[i]);
      else push_ev(EV_WORD, init_tbl[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_n);
    rst = 1'b0;
    @(negedge clk_n);
    check("rst_wr_valid", 32'(wr_valid), 0);
    check("rst_wr_word", 32'(wr_word), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_idx", 32'(err_idx), 0);
    check("rst_acks", {30'b0, ack_mute, ack_vol}, 0);
    @(negedge clk_n);
    rst = 1'b1;
    @(negedge clk_n);
    check("rel_busy", 32'(busy), 1);
  endtask

  task automatic wait_init(input bit check_gap);
    int n = 0;
    while (!init_done && !err && n < 3000) begin
      @(negedge clk_n);
      n++;
    end
    check("init_timeout", 32'(n < 3000), 1);
    if (check_gap && init_done) check("init_gap_cycles", 32'(cyc - last_done_cyc), GAP + 1);
  endtask

  task automatic wait_ack(input int which);
    bit found = 0;
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clk_n);
      if ((which == EV_MUTE && ack_mute) || (which == EV_VOL && ack_vol)) found = 1;
    end
    check("ack_timeout", 32'(found), 1);
  endtask

  task automatic wait_word(input logic [15:0] w, input bit need_ready);
    bit found = 0;
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clk_n);
      if (wr_valid && wr_word == w && (!need_ready || wr_ready)) found = 1;
    end
    check("word_timeout", 32'(found), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: clean init, all ACKs.
    push_init(-1, 0, 10);
    do_reset();
    wait_init(1);
    check("t1_init_done", 32'(init_done), 1);
    check("t1_err", 32'(err), 0);
    check("t1_busy", 32'(busy), 0);
    check("t1_queue", 32'(exp_q.size()), 0);

    // 2: idx 3 NACKed twice, then ACKed.
    nack_word  = 16'h0217;
    nack_limit = 2;
    push_init(3, 3, 10);
    do_reset();
    wait_init(1);
    check("t2_init_done", 32'(init_done), 1);
    check("t2_err", 32'(err), 0);
    check("t2_queue", 32'(exp_q.size()), 0);

    // 3: idx 7 always NACKed -> ERROR, requests ignored.
    nack_word  = 16'h0E42;
    nack_limit = 1000;
    push_init(7, 4, 8);
    do_reset();
    wait_init(0);
    check("t3_err", 32'(err), 1);
    check("t3_err_idx", 32'(err_idx), 7);
    check("t3_busy", 32'(busy), 0);
    check("t3_init_done", 32'(init_done), 0);
    begin
      int acks_before = ack_count;
      req_vol  = 1'b1;
      vol_data = 7'h70;
      repeat (200) @(negedge clk_n);
      check("t3_no_ack", 32'(ack_count - acks_before), 0);
      check("t3_no_valid", 32'(wr_valid), 0);
      req_vol = 1'b0;
    end
    check("t3_queue", 32'(exp_q.size()), 0);

    // 4: simultaneous mute and volume after init.
    nack_limit = 0;
    push_init(-1, 0, 10);
    do_reset();
    wait_init(1);
    push_ev(EV_WORD, 16'h0A08);
    push_ev(EV_MUTE, 16'h0);
    push_ev(EV_WORD, 16'h0570);
    push_ev(EV_VOL, 16'h0);
    @(negedge clk_n);
    req_mute = 1'b1;
    mute_en  = 1'b1;
    req_vol  = 1'b1;
    vol_data = 7'h70;
    wait_ack(EV_MUTE);
    req_mute = 1'b0;
    wait_ack(EV_VOL);
    req_vol = 1'b0;
    repeat (10) @(negedge clk_n);
    check("t4_err", 32'(err), 0);
    check("t4_busy", 32'(busy), 0);
    check("t4_queue", 32'(exp_q.size()), 0);

    // 5: volume request raised during init idx 2 waits for init_done.
    push_init(-1, 0, 10);
    push_ev(EV_WORD, 16'h0570);
    push_ev(EV_VOL, 16'h0);
    do_reset();
    wait_word(16'h0017, 1'b0);
    req_vol  = 1'b1;
    vol_data = 7'h70;
    wait_init(1);
    @(negedge clk_n);
    check("t5_valid_after_init", 32'(wr_valid), 1);
    check("t5_word_after_init", 32'(wr_word), 32'h0570);
    wait_ack(EV_VOL);
    req_vol = 1'b0;
    repeat (10) @(negedge clk_n);
    check("t5_err", 32'(err), 0);
    check("t5_queue", 32'(exp_q.size()), 0);

    // 6: reset while waiting on idx 5, then full restart.
    push_init(-1, 0, 6);
    do_reset();
    wait_word(16'h0814, 1'b1);
    repeat (3) @(negedge clk_n);
    check("t6_queue_pre", 32'(exp_q.size()), 0);
    push_init(-1, 0, 10);
    do_reset();
    wait_init(1);
    check("t6_init_done", 32'(init_done), 1);
    check("t6_err", 32'(err), 0);
    check("t6_queue", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
